// File: rtl/m31_pkg.sv
// m31_pkg: Mersenne-31 field types and helpers shared by the Poseidon2 datapath.
//   m31_t        31-bit canonical field element, value range [0, P_M31-1]
//   m31_state_t  one Poseidon2 state vector (N_LANES_P2 lanes)
//   m31_add      canonical modular addition
package m31_pkg;

    typedef logic [30:0] m31_t;

    localparam m31_t P_M31      = 31'h7FFF_FFFF;
    localparam int   N_LANES_P2 = 16;

    typedef m31_t m31_state_t [N_LANES_P2];

    // Accepts operands equal to P as well, so the result is canonical even for P+P.
    function automatic m31_t m31_add(input m31_t a, input m31_t b);
        logic [31:0] s;
        m31_t        r;
        s = {1'b0, a} + {1'b0, b};
        r = s[30:0] + {30'b0, s[31]};
        return (r == P_M31) ? '0 : r;
    endfunction

endpackage

// File: rtl/m31_arc_lane.sv
// m31_arc_lane: one lane of add-round-constant followed by the x^5 S-box, 16-cycle latency.
//   clk, rst_n  clock, async active-low reset
//   x_i, rc_i   state element and round constant (may be P, treated as 0)
//   t5_o        ((x_i + rc_i) mod P)^5 mod P
module m31_arc_lane
    import m31_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  m31_t x_i,
    input  m31_t rc_i,
    output m31_t t5_o
);

    localparam int TD = 10;

    m31_t t_q;
    m31_t t_dq [TD];
    m31_t t2, t4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q <= '0;
            for (int i = 0; i < TD; i++) t_dq[i] <= '0;
        end else begin
            t_q     <= m31_add(x_i, rc_i);
            t_dq[0] <= t_q;
            for (int i = 1; i < TD; i++) t_dq[i] <= t_dq[i-1];
        end
    end

    m31_sqr u_sq1 (.clk(clk), .rst_n(rst_n), .a_i(t_q), .y_o(t2));
    m31_sqr u_sq2 (.clk(clk), .rst_n(rst_n), .a_i(t2),  .y_o(t4));

    // t_dq[TD-1] is t delayed by both squarers, so it meets t^4 in the same cycle.
    m31_mul u_mul (.clk(clk), .rst_n(rst_n), .a_i(t4), .b_i(t_dq[TD-1]), .y_o(t5_o));

endmodule

// File: rtl/m31_mul.sv
// m31_mul: 5-cycle pipelined modular multiplier over M31.
//   clk, rst_n  clock, async active-low reset
//   a_i, b_i    canonical operands
//   y_o         a_i*b_i mod P, 5 cycles later, canonical
module m31_mul
    import m31_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  m31_t a_i,
    input  m31_t b_i,
    output m31_t y_o
);

    m31_t        a_q, b_q, r_q, y_q;
    logic [61:0] p_q;
    logic [31:0] s_q, s_d;
    m31_t        r_d, y_d;

    // 2^31 == 1 mod P, so the high half folds straight onto the low half.
    always_comb begin
        s_d = {1'b0, p_q[30:0]} + {1'b0, p_q[61:31]};
        r_d = s_q[30:0] + {30'b0, s_q[31]};
        y_d = (r_q == P_M31) ? '0 : r_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            p_q <= '0;
            s_q <= '0;
            r_q <= '0;
            y_q <= '0;
        end else begin
            a_q <= a_i;
            b_q <= b_i;
            p_q <= {31'b0, a_q} * {31'b0, b_q};
            s_q <= s_d;
            r_q <= r_d;
            y_q <= y_d;
        end
    end

    assign y_o = y_q;

endmodule

// File: rtl/m31_sqr.sv
// m31_sqr: 5-cycle pipelined modular squarer over M31.
//   clk, rst_n  clock, async active-low reset
//   a_i         canonical operand
//   y_o         a_i^2 mod P, 5 cycles later
module m31_sqr
    import m31_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  m31_t a_i,
    output m31_t y_o
);

    m31_mul u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .a_i   (a_i),
        .b_i   (a_i),
        .y_o   (y_o)
    );

endmodule

// File: rtl/m31_arc_sbox.sv
// m31_arc_sbox: Poseidon2 round front-end over M31 (add round constant, then t^5 per lane).
//   clk, rst_n    clock, async active-low reset
//   in_valid_i    input beat valid (no backpressure)
//   full_round_i  1 = all lanes through S-box, 0 = lane 0 only, other lanes pass through
//   state_i, rc_i input state and round constants
//   out_valid_o, full_round_o, state_o  same beat, 16 cycles later
//   err_o         sticky flag for a used input lane equal to P
//                 (port exists only when M31_ARC_SBOX_CANON_CHK_EN is defined)
module m31_arc_sbox
    import m31_pkg::*;
#(
    parameter int N_LANES = N_LANES_P2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid_i,
    input  logic full_round_i,
    input  m31_t state_i [N_LANES],
    input  m31_t rc_i    [N_LANES],
    output logic out_valid_o,
    output logic full_round_o,
    output m31_t state_o [N_LANES]
`ifdef M31_ARC_SBOX_CANON_CHK_EN
   ,output logic err_o
`endif
);

    localparam int LAT = 16;

    logic [LAT-1:0] vld_q, fr_q;
    m31_t           pt_q [LAT][N_LANES];
    m31_t           sbox [N_LANES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            fr_q  <= '0;
            for (int i = 0; i < LAT; i++)
                for (int k = 0; k < N_LANES; k++) pt_q[i][k] <= '0;
        end else begin
            vld_q <= {vld_q[LAT-2:0], in_valid_i};
            fr_q  <= {fr_q[LAT-2:0], full_round_i};
            pt_q[0] <= state_i;
            for (int i = 1; i < LAT; i++) pt_q[i] <= pt_q[i-1];
        end
    end

    // Every lane computes its S-box regardless of round type; the round type only picks the result.
    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        m31_arc_lane u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .x_i   (state_i[k]),
            .rc_i  (rc_i[k]),
            .t5_o  (sbox[k])
        );
    end

    always_comb begin
        for (int k = 0; k < N_LANES; k++)
            state_o[k] = (k == 0 || fr_q[LAT-1]) ? sbox[k] : pt_q[LAT-1][k];
    end

    assign out_valid_o  = vld_q[LAT-1];
    assign full_round_o = fr_q[LAT-1];

`ifdef M31_ARC_SBOX_CANON_CHK_EN
    logic err_q, err_d, bad;

    // Passthrough lanes of a partial round are not field inputs to the round, so they are not checked.
    always_comb begin
        bad = (state_i[0] == P_M31) || (rc_i[0] == P_M31);
        for (int k = 1; k < N_LANES; k++)
            bad = bad || (full_round_i && (state_i[k] == P_M31 || rc_i[k] == P_M31));
        err_d = err_q || (in_valid_i && bad);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_m31_arc_sbox.sv
// tb_m31_arc_sbox: randomized scoreboard bench for m31_arc_sbox against an arithmetic model.
module tb_m31_arc_sbox;
    import m31_pkg::*;

    localparam int NL  = 16;
    localparam int LAT = 16;
    localparam longint unsigned PM = 64'h7FFF_FFFF;

    typedef struct {
        bit          fr;
        int unsigned cyc;
        m31_t        st [NL];
    } exp_t;

    logic clk = 0;
    logic rst_n = 0;
    logic in_valid_i = 0;
    logic full_round_i = 0;
    m31_t state_i [NL];
    m31_t rc_i    [NL];
    logic out_valid_o, full_round_o;
    m31_t state_o [NL];
`ifdef M31_ARC_SBOX_CANON_CHK_EN
    logic err_o;
`endif

    m31_t st_v [NL];
    m31_t rc_v [NL];
    exp_t q [$];
    int unsigned cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    m31_arc_sbox dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid_i),
        .full_round_i (full_round_i),
        .state_i      (state_i),
        .rc_i         (rc_i),
        .out_valid_o  (out_valid_o),
        .full_round_o (full_round_o),
        .state_o      (state_o)
`ifdef M31_ARC_SBOX_CANON_CHK_EN
       ,.err_o        (err_o)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic longint unsigned mm(input longint unsigned a, input longint unsigned b);
        return (a * b) % PM;
    endfunction

    function automatic longint unsigned pow5(input longint unsigned t);
        longint unsigned t2;
        t2 = mm(t, t);
        return mm(mm(t2, t2), t);
    endfunction

    function automatic m31_t rnd();
        int unsigned r;
        r = $urandom_range(0, 15);
        if (r == 0) return P_M31;
        if (r == 1) return P_M31 - 31'd1;
        if (r == 2) return m31_t'($urandom_range(0, 3));
        return m31_t'($urandom_range(0, 32'h7FFF_FFFF));
    endfunction

    task automatic randomize_vecs();
        for (int k = 0; k < NL; k++) begin
            st_v[k] = rnd();
            rc_v[k] = rnd();
        end
    endtask

    task automatic send(input bit fr);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid_i   = 1;
        full_round_i = fr;
        state_i      = st_v;
        rc_i         = rc_v;
        e.fr  = fr;
        e.cyc = cyc;
        for (int k = 0; k < NL; k++) begin
            if (fr || k == 0)
                e.st[k] = m31_t'(pow5(((longint'(st_v[k]) + longint'(rc_v[k])) % PM)));
            else
                e.st[k] = st_v[k];
        end
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid_i   = 0;
            full_round_i = $urandom_range(0, 1);
            for (int k = 0; k < NL; k++) begin
                state_i[k] = rnd();
                rc_i[k]    = rnd();
            end
        end
    endtask

    always @(negedge clk) begin
        if (out_valid_o) begin
            if (!rst_n || q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("latency", cyc, e.cyc + LAT);
                chk("full_round_o", full_round_o, e.fr);
                for (int k = 0; k < NL; k++)
                    chk($sformatf("lane%0d", k), state_o[k], e.st[k]);
            end
        end
    end

    initial begin
        for (int k = 0; k < NL; k++) begin
            state_i[k] = '0;
            rc_i[k]    = '0;
        end
        #1;
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_full_round", full_round_o, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state0", state_o[0], 0);
`ifdef M31_ARC_SBOX_CANON_CHK_EN
        chk("rst_err", err_o, 0);
`endif
        rst_n = 1;
        idle(2);

        for (int k = 0; k < NL; k++) begin
            st_v[k] = 31'd2;
            rc_v[k] = 31'd1;
        end
        send(1);
        idle(3);

        st_v[0] = P_M31 - 31'd1; rc_v[0] = 31'd0;
        st_v[1] = P_M31 - 31'd1; rc_v[1] = 31'd2;
        st_v[2] = 31'h10000;     rc_v[2] = 31'd0;
        st_v[3] = P_M31;         rc_v[3] = P_M31;
        send(1);
        idle(1);

        for (int k = 0; k < NL; k++) begin
            st_v[k] = 31'd5;
            rc_v[k] = 31'd7;
        end
        st_v[0] = 31'd1;
        rc_v[0] = 31'd1;
        send(0);
        idle(2);

        for (int b = 0; b < 200; b++) begin
            randomize_vecs();
            send($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(LAT + 4);
        chk("drain_random", q.size(), 0);

        for (int b = 0; b < 20; b++) begin
            randomize_vecs();
            send($urandom_range(0, 1));
        end
        #1;
        rst_n      = 0;
        in_valid_i = 0;
        q.delete();
        #1;
        chk("reset_clears_valid", out_valid_o, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
`ifdef M31_ARC_SBOX_CANON_CHK_EN
        chk("err_after_reset", err_o, 0);
`endif
        idle(LAT + 2);
        randomize_vecs();
        send(1);
        idle(LAT + 4);
        chk("drain_after_reset", q.size(), 0);

`ifdef M31_ARC_SBOX_CANON_CHK_EN
        for (int k = 0; k < NL; k++) begin
            st_v[k] = m31_t'($urandom_range(0, 32'h7FFF_FFFE));
            rc_v[k] = m31_t'($urandom_range(0, 32'h7FFF_FFFE));
        end
        st_v[3] = P_M31;
        send(0);
        idle(3);
        chk("err_partial_lane3", err_o, 0);
        send(1);
        @(posedge clk);
        #1;
        in_valid_i = 0;
        chk("err_set", err_o, 1);
        idle(5);
        chk("err_sticky", err_o, 1);
        idle(LAT);
        chk("drain_chk", q.size(), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
